// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared state encodings and counter widths for dual_input_sampler
package sampler_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_STABLE = 2'd2
  } state_t;

  localparam int STABLE_CNT_W = 4;
  localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser for an asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dual_input_sampler.sv
// rtl/dual_input_sampler.sv - synchronise, tick-sample and debounce two raw levels feeding and_gate
// Optional glitch counter port enabled by SAMPLER_GLITCH_CNT_EN.
module dual_input_sampler
  import sampler_pkg::*;
#(
  parameter int SAMPLE_DIV     = 100,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw_1,
  input  logic raw_2,
  output logic input_1,
  output logic input_2,
  output logic sample_valid,
  output logic changed
`ifdef SAMPLER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

  localparam int PRESC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PRESC_W-1:0]      PRESC_MAX  = PRESC_W'(SAMPLE_DIV - 1);
  localparam logic [STABLE_CNT_W-1:0] STABLE_TGT = STABLE_CNT_W'(STABLE_SAMPLES);
  localparam logic [STABLE_CNT_W-1:0] CNT_ONE    = STABLE_CNT_W'(1);

  logic                    w_sync_1;
  logic                    w_sync_2;
  logic [1:0]              w_sync_pair;
  logic                    w_tick;

  logic [PRESC_W-1:0]      r_presc;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_cand;
  logic [1:0]              w_cand_nxt;
  logic [STABLE_CNT_W-1:0] r_cnt;
  logic [STABLE_CNT_W-1:0] w_cnt_nxt;
  logic [1:0]              r_out;
  logic                    w_load;
  logic                    r_changed;
  logic                    r_sample_valid;

  sync_2ff u_sync_1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (raw_1),
    .o_q   (w_sync_1)
  );

  sync_2ff u_sync_2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (raw_2),
    .o_q   (w_sync_2)
  );

  assign w_sync_pair = {w_sync_2, w_sync_1};
  assign w_tick      = en && (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (!en || (r_presc == PRESC_MAX)) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Both output bits load together from cand, only on entry to (or re-confirmation in) S_STABLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
        end
        S_SETTLE: begin
          if (w_tick) begin
            if (w_sync_pair == r_cand) begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end else begin
              w_cand_nxt = w_sync_pair;
              w_cnt_nxt  = CNT_ONE;
            end
            if (w_cnt_nxt == STABLE_TGT) begin
              w_state_nxt = S_STABLE;
              w_load      = (w_cand_nxt != r_out);
            end
          end
        end
        S_STABLE: begin
          if (w_tick && (w_sync_pair != r_cand)) begin
            w_cand_nxt = w_sync_pair;
            w_cnt_nxt  = CNT_ONE;
            // With a single-sample debounce a new value is confirmed on its first tick.
            if (CNT_ONE == STABLE_TGT) begin
              w_load = (w_cand_nxt != r_out);
            end else begin
              w_state_nxt = S_SETTLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cand         <= 2'b00;
      r_cnt          <= '0;
      r_out          <= 2'b00;
      r_changed      <= 1'b0;
      r_sample_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cand         <= w_cand_nxt;
      r_cnt          <= w_cnt_nxt;
      r_changed      <= w_load;
      r_sample_valid <= w_tick;
      if (w_load) begin
        r_out <= w_cand_nxt;
      end
    end
  end

`ifdef SAMPLER_GLITCH_CNT_EN
  logic                    w_glitch_inc;
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  assign w_glitch_inc = w_tick && (r_state == S_SETTLE) &&
                        (w_sync_pair != r_cand) && (r_cnt < STABLE_TGT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch_inc && (r_glitch_cnt != {GLITCH_CNT_W{1'b1}})) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign glitch_count = r_glitch_cnt;
`endif

  assign input_1      = r_out[0];
  assign input_2      = r_out[1];
  assign sample_valid = r_sample_valid;
  assign changed      = r_changed;

endmodule

// File: tb/tb_dual_input_sampler.sv
// tb/tb_dual_input_sampler.sv - directed self-checking bench for dual_input_sampler driving an and_gate model
module tb_dual_input_sampler;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic raw_1;
  logic raw_2;
  logic input_1;
  logic input_2;
  logic sample_valid;
  logic changed;
  logic and_result;
`ifdef SAMPLER_GLITCH_CNT_EN
  logic [7:0] glitch_count;
  int         g0;
`endif

  int         n_tests;
  int         n_fail;
  int         n_sv;
  int         n_chg;
  int         n_unflagged;
  int         cyc;
  logic [1:0] prev_out;

  always #5 clk = ~clk;

  assign and_result = input_1 & input_2;

  dual_input_sampler #(
    .SAMPLE_DIV     (4),
    .STABLE_SAMPLES (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .raw_1        (raw_1),
    .raw_2        (raw_2),
    .input_1      (input_1),
    .input_2      (input_2),
    .sample_valid (sample_valid),
    .changed      (changed)
`ifdef SAMPLER_GLITCH_CNT_EN
    ,
    .glitch_count (glitch_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, sampled on the falling edge; tallies pulses and any output move without changed.
  task automatic step();
    @(negedge clk);
    if (sample_valid) n_sv++;
    if (changed) n_chg++;
    if (({input_2, input_1} != prev_out) && !changed) n_unflagged++;
    prev_out = {input_2, input_1};
  endtask

  task automatic clr_counts();
    n_sv        = 0;
    n_chg       = 0;
    n_unflagged = 0;
  endtask

  task automatic wait_out(input logic [1:0] exp, input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (({input_2, input_1} != exp) && (cycles < budget));
  endtask

  task automatic wait_sv(input int n, input int budget);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while ((n_sv < n) && (c < budget));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    prev_out = 2'b00;
    clr_counts();
    rst_n = 1'b0;
    en    = 1'b0;
    raw_1 = 1'b1;
    raw_2 = 1'b1;

    // 1: reset and hold with en low
    repeat (3) step();
    check_eq("rst_input_1", input_1, 0);
    check_eq("rst_input_2", input_2, 0);
    check_eq("rst_sample_valid", sample_valid, 0);
`ifdef SAMPLER_GLITCH_CNT_EN
    check_eq("rst_glitch_count", glitch_count, 0);
`endif
    rst_n = 1'b1;
    clr_counts();
    repeat (20) step();
    check_eq("hold_outputs", {input_2, input_1}, 2'b00);
    check_eq("hold_no_sample_valid", n_sv, 0);

    // 2: debounce a single-bit change, then the second bit
    raw_1 = 1'b1;
    raw_2 = 1'b0;
    en    = 1'b1;
    clr_counts();
    wait_out(2'b01, 40, cyc);
    check_eq("t2_out_01", {input_2, input_1}, 2'b01);
    check_eq("t2_latency", cyc, 12);
    repeat (5) step();
    check_eq("t2_changed_pulses", n_chg, 1);
    check_eq("t2_and_result_low", and_result, 0);
    check_eq("t2_unflagged_moves", n_unflagged, 0);

    raw_2 = 1'b1;
    clr_counts();
    wait_out(2'b11, 40, cyc);
    check_eq("t2b_out_11", {input_2, input_1}, 2'b11);
    check_eq("t2b_within_15", {31'd0, cyc <= 15}, 1);
    check_eq("t2b_and_result_high", and_result, 1);

    // 3: glitch on raw_2 from a stable 00
    raw_1 = 1'b0;
    raw_2 = 1'b0;
    wait_out(2'b00, 40, cyc);
    check_eq("t3_settle_00", {input_2, input_1}, 2'b00);
`ifdef SAMPLER_GLITCH_CNT_EN
    g0 = int'(glitch_count);
`endif
    clr_counts();
    raw_2 = 1'b1;
    repeat (5) step();
    raw_2 = 1'b0;
    repeat (30) step();
    check_eq("t3_out_held", {input_2, input_1}, 2'b00);
    check_eq("t3_no_changed", n_chg, 0);
    check_eq("t3_unflagged_moves", n_unflagged, 0);
`ifdef SAMPLER_GLITCH_CNT_EN
    check_eq("t3_glitch_delta", int'(glitch_count) - g0, 1);
`endif

    // 4: simultaneous change of both lines
    clr_counts();
    raw_1 = 1'b1;
    raw_2 = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!input_1 && (cyc < 40));
    check_eq("t4_input_1_rose", input_1, 1);
    check_eq("t4_input_2_same_clk", input_2, 1);
    check_eq("t4_changed_at_update", changed, 1);
    repeat (8) step();
    check_eq("t4_one_changed", n_chg, 1);
    check_eq("t4_unflagged_moves", n_unflagged, 0);

    // 5: asynchronous reset mid-settle
    clr_counts();
    raw_1 = 1'b0;
    raw_2 = 1'b0;
    wait_sv(2, 20);
    check_eq("t5_two_ticks", n_sv, 2);
    check_eq("t5_pre_reset_out", {input_2, input_1}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_clear", {input_2, input_1}, 2'b00);
`ifdef SAMPLER_GLITCH_CNT_EN
    check_eq("t5_glitch_clear", glitch_count, 0);
`endif
    raw_1 = 1'b1;
    raw_2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    prev_out = 2'b00;
    rst_n    = 1'b1;
    clr_counts();
    wait_out(2'b11, 40, cyc);
    check_eq("t5_out_11", {input_2, input_1}, 2'b11);
    check_eq("t5_ticks_to_update", n_sv, 3);
    check_eq("t5_changed_at_update", changed, 1);

    // 6: en dropped during settle restarts the debounce
    clr_counts();
    raw_1 = 1'b0;
    raw_2 = 1'b0;
    wait_sv(1, 20);
    check_eq("t6_one_tick", n_sv, 1);
`ifdef SAMPLER_GLITCH_CNT_EN
    g0 = int'(glitch_count);
`endif
    en = 1'b0;
    clr_counts();
    repeat (10) step();
    check_eq("t6_no_sv_while_off", n_sv, 0);
    check_eq("t6_out_held", {input_2, input_1}, 2'b11);
`ifdef SAMPLER_GLITCH_CNT_EN
    check_eq("t6_glitch_held", int'(glitch_count), g0);
`endif
    en = 1'b1;
    clr_counts();
    wait_out(2'b00, 40, cyc);
    check_eq("t6_out_00", {input_2, input_1}, 2'b00);
    check_eq("t6_ticks_after_reenable", n_sv, 3);
    check_eq("t6_one_changed", n_chg, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
